ladybird_uart_transmitter: RTL and testbench

UART transmitter: 8N1 framing, LSB first, fixed bit period of WTIME clocks. Bytes arrive over a valid/ready stream and are buffered in a small FIFO. A bit-timing FSM serialises each byte onto tx. It is the transmit-side counterpart of the ladybird UART receiver, and both share WTIME so a loopback pair agrees on baud rate.

---
 rtl/ladybird_uart_pkg.sv | 30 +++
 rtl/ladybird_uart_transmitter_if.sv | 12 +
 rtl/ladybird_uart_tx_fifo.sv | 67 ++++++
 rtl/ladybird_uart_transmitter.sv | 139 +++++++++++++
 tb/tb_ladybird_uart_transmitter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_uart_pkg.sv
// Shared definitions for the ladybird UART pair (transmitter and receiver).
// Both sides take their bit period and frame shape from here, so a loopback
// pair always agrees on baud rate and framing.
package ladybird_uart_pkg;

   // Bit period in clk cycles shared with the receiver.
   localparam int unsigned DEFAULT_WTIME = 16'h28B0;

   // Frame shape: one start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned IDX_W     = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   // Line level for a given frame phase; only DATA depends on the shifter.
   function automatic logic tx_level(input tx_state_e s, input logic lsb);
      case (s)
         START:   return 1'b0;
         DATA:    return lsb;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ladybird_uart_transmitter_if.sv
// Byte stream into the transmitter: valid/data from the producer, ready back.
interface ladybird_uart_transmitter_if;
   import ladybird_uart_pkg::*;

   logic                 valid;
   logic [DATA_BITS-1:0] data;
   logic                 ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ladybird_uart_tx_fifo.sv
// Small power-of-two FIFO with an occupancy count and a registered ready.
// Reads are fall-through: rdata always shows the head entry.
module ladybird_uart_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW   = $clog2(DEPTH + 1),
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             ready,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_push = push && (count != FULL);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy after this edge; a simultaneous push and pop cancel out.
   always_comb begin
      // NOTE: default assigned first so every path writes count_next and no latch is inferred.
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Pointers, count and ready; ready is computed from the count being committed.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop here samples pre-edge values, independent of statement order.
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         ready <= (count_next != FULL);
      end
   end

   // Storage array, written on push.
   // NOTE: storage is deliberately not reset; entries are only read behind a non-zero count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ladybird_uart_transmitter.sv
// 8N1 UART transmitter. Bytes are buffered in a small FIFO and serialised LSB
// first, each bit held for WTIME clocks. Queued bytes follow each other with
// no idle gap between a stop bit and the next start bit.
module ladybird_uart_transmitter
   import ladybird_uart_pkg::*;
#(
   parameter int unsigned WTIME = DEFAULT_WTIME,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      arst,
   ladybird_uart_transmitter_if.slave bus,
   output logic                      tx,
   output logic                      busy
);

   localparam int unsigned      CW        = $clog2(DEPTH + 1);
   localparam logic [15:0]      RELOAD    = 16'(WTIME - 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   tx_state_e            state;
   tx_state_e            state_next;
   logic [15:0]          cnt;
   logic [15:0]          cnt_next;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_next;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] sh_next;

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic [CW-1:0]        fifo_count;

   assign fifo_push = bus.valid & bus.ready;

   ladybird_uart_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .arst  (arst),
      .push  (fifo_push),
      .wdata (bus.data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .ready (bus.ready),
      .count (fifo_count)
   );

   // Bit-timing FSM: every phase lasts until the down-counter reaches zero.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      sh_next    = sh;
      fifo_pop   = 1'b0;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               sh_next    = fifo_rdata;
               cnt_next   = RELOAD;
               state_next = START;
            end
         end

         START: begin
            if (cnt == '0) begin
               cnt_next   = RELOAD;
               idx_next   = '0;
               state_next = DATA;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end

         DATA: begin
            if (cnt == '0) begin
               sh_next  = {1'b0, sh[DATA_BITS-1:1]};
               cnt_next = RELOAD;
               if (idx == LAST_DATA) begin
                  idx_next   = '0;
                  state_next = STOP;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end

         STOP: begin
            if (cnt == '0) begin
               if (idx != LAST_STOP) begin
                  idx_next = idx + IDX_W'(1);
                  cnt_next = RELOAD;
               end else if (!fifo_empty) begin
                  // Chain straight into the next frame's start bit.
                  fifo_pop   = 1'b1;
                  sh_next    = fifo_rdata;
                  cnt_next   = RELOAD;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // FSM state plus registered line and busy outputs; tx follows the current phase one cycle later.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         tx    <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         idx   <= idx_next;
         sh    <= sh_next;
         tx    <= tx_level(state, sh[0]);
         busy  <= (state != IDLE) || (fifo_count != '0);
      end
   end

endmodule

// File: tb/tb_ladybird_uart_transmitter.sv
// Bench for ladybird_uart_transmitter: one instance at WTIME=16 and one at the
// minimum WTIME=2, both DEPTH=4, sharing clock and reset.
module tb_ladybird_uart_transmitter;
   import ladybird_uart_pkg::*;

   logic clk  = 1'b0;
   logic arst = 1'b0;
   logic tx16, busy16, tx2, busy2;

   int n_checks = 0;
   int n_errors = 0;

   ladybird_uart_transmitter_if bus16 ();
   ladybird_uart_transmitter_if bus2 ();

   always #5 clk = ~clk;

   ladybird_uart_transmitter #(.WTIME(16), .DEPTH(4)) u16 (
      .clk (clk), .arst (arst), .bus (bus16), .tx (tx16), .busy (busy16)
   );

   ladybird_uart_transmitter #(.WTIME(2), .DEPTH(4)) u2 (
      .clk (clk), .arst (arst), .bus (bus2), .tx (tx2), .busy (busy2)
   );

   // One single-byte frame: which instance, the byte, and the expected line
   // levels in transmit order (bit 0 = start bit, bit 9 = stop bit).
   typedef struct {
      bit         fast;
      logic [7:0] data;
      logic [9:0] bits;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] stim [0:15];
   int         accept_cyc [0:15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input bit fast);
      return fast ? tx2 : tx16;
   endfunction

   function automatic logic busy_of(input bit fast);
      return fast ? busy2 : busy16;
   endfunction

   function automatic logic ready_of(input bit fast);
      return fast ? bus2.ready : bus16.ready;
   endfunction

   task automatic drive(input bit fast, input logic v, input logic [7:0] d);
      if (fast) begin
         bus2.valid = v;
         bus2.data  = d;
      end else begin
         bus16.valid = v;
         bus16.data  = d;
      end
   endtask

   task automatic wait_idle(input bit fast, input int budget, input string tag);
      int n;
      n = 0;
      while (busy_of(fast) !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_idle"}, busy_of(fast), 1'b0);
   endtask

   // Push one byte into an idle instance and follow its frame cycle by cycle.
   task automatic single_frame(input int i, input vec_t v);
      int         w;
      logic [9:0] mid;
      logic       unstable;
      string      tag;
      w        = v.fast ? 2 : 16;
      mid      = '0;
      unstable = 1'b0;
      tag      = $sformatf("vec%0d", i);
      check({tag, "_ready"}, ready_of(v.fast), 1'b1);
      drive(v.fast, 1'b1, v.data);
      step();                                   // accept edge N
      drive(v.fast, 1'b0, 8'h00);
      check({tag, "_tx_n"}, tx_of(v.fast), 1'b1);
      step();                                   // edge N+1: pop
      check({tag, "_tx_n1"}, tx_of(v.fast), 1'b1);
      step();                                   // edge N+2: start bit on the line
      for (int c = 0; c < 10 * w; c++) begin
         if (c > 0) step();
         if (tx_of(v.fast) !== v.bits[c / w]) unstable = 1'b1;
         if (c % w == w / 2) mid[c / w] = tx_of(v.fast);
      end
      for (int k = 0; k < 10; k++)
         check($sformatf("%s_bit%0d", tag, k), mid[k], v.bits[k]);
      check({tag, "_bit_width"}, unstable, 1'b0);
      check({tag, "_busy_last"}, busy_of(v.fast), 1'b1);
      step();
      check({tag, "_busy_end"}, busy_of(v.fast), 1'b0);
      check({tag, "_tx_end"}, tx_of(v.fast), 1'b1);
   endtask

   // Receiver model: decode n frames, expecting stim[0..n-1]; frames after
   // the first must start on the cycle right after the previous stop bit.
   task automatic rx_frames(input bit fast, input int n, input int budget, input string tag);
      int         w;
      int         waited;
      logic [7:0] got;
      w = fast ? 2 : 16;
      for (int f = 0; f < n; f++) begin
         waited = 0;
         while (tx_of(fast) !== 1'b0 && waited < budget) begin
            step();
            waited++;
         end
         check($sformatf("%s_start%0d", tag, f), tx_of(fast), 1'b0);
         if (tx_of(fast) !== 1'b0) return;
         if (f > 0) check($sformatf("%s_gap%0d", tag, f), waited, 0);
         repeat (w / 2) step();
         check($sformatf("%s_startmid%0d", tag, f), tx_of(fast), 1'b0);
         for (int b = 0; b < 8; b++) begin
            repeat (w) step();
            got[b] = tx_of(fast);
         end
         repeat (w) step();
         check($sformatf("%s_stop%0d", tag, f), tx_of(fast), 1'b1);
         check($sformatf("%s_byte%0d", tag, f), got, stim[f]);
         repeat (w - w / 2) step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int cyc;
      int first_drop;
      int low_cnt;
      logic fire;

      vecs[0] = '{1'b0, 8'hA5, 10'b1101001010};
      vecs[1] = '{1'b0, 8'h3C, 10'b1001111000};
      vecs[2] = '{1'b1, 8'h81, 10'b1100000010};
      vecs[3] = '{1'b1, 8'h5A, 10'b1010110100};
      vecs[4] = '{1'b0, 8'h00, 10'b1000000000};
      vecs[5] = '{1'b1, 8'hFF, 10'b1111111110};

      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);

      // Reset: outputs forced at once, ready only after the first edge past release.
      #2 arst = 1'b1;
      #1;
      check("rst_tx", tx16, 1'b1);
      check("rst_ready", bus16.ready, 1'b0);
      check("rst_busy", busy16, 1'b0);
      repeat (2) step();
      #2 arst = 1'b0;
      #1;
      check("rel_ready_before_edge", bus16.ready, 1'b0);
      step();
      check("rel_ready16", bus16.ready, 1'b1);
      check("rel_ready2", bus2.ready, 1'b1);
      check("rel_busy", busy16, 1'b0);

      // Single frames at WTIME=16 and WTIME=2.
      for (int i = 0; i < 6; i++) single_frame(i, vecs[i]);

      // Back-to-back bytes on consecutive edges: contiguous frames, in order.
      stim[0] = 8'h00;
      stim[1] = 8'hFF;
      stim[2] = 8'h55;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               drive(1'b0, 1'b1, stim[i]);
               step();
            end
            drive(1'b0, 1'b0, 8'h00);
         end
         rx_frames(1'b0, 3, 20, "b2b");
      join
      wait_idle(1'b0, 100, "b2b");

      // FIFO full: valid held for ten bytes, ready throttles the producer.
      for (int i = 0; i < 10; i++) stim[i] = 8'(i + 1);
      fork
         begin
            sent       = 0;
            cyc        = 0;
            first_drop = -1;
            drive(1'b0, 1'b1, stim[0]);
            while (sent < 10 && cyc < 4000) begin
               fire = bus16.ready;
               if (!fire && first_drop < 0) first_drop = sent;
               step();
               cyc++;
               if (fire) begin
                  accept_cyc[sent] = cyc;
                  sent++;
                  if (sent < 10) drive(1'b0, 1'b1, stim[sent]);
               end
            end
            drive(1'b0, 1'b0, 8'h00);
         end
         rx_frames(1'b0, 10, 20, "full");
      join
      check("full_sent", sent, 10);
      check("full_first_drop", first_drop, 5);
      check("full_rerise_first", accept_cyc[5] - accept_cyc[4], 158);
      for (int k = 6; k < 10; k++)
         check($sformatf("full_gap%0d", k), accept_cyc[k] - accept_cyc[k - 1], 160);
      wait_idle(1'b0, 100, "full");

      // Push on the same edge as a STOP-to-START pop with three bytes queued.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'(8'h11 * (i + 1)));
         step();                                // edges N..N+3; start bit appears after N+2
      end
      drive(1'b0, 1'b0, 8'h00);
      check("pp_tx_low", tx16, 1'b0);
      repeat (157) step();                      // one cycle before the pop edge
      check("pp_count_before", u16.fifo_count, 3);
      check("pp_tx_stop", tx16, 1'b1);
      drive(1'b0, 1'b1, 8'h55);
      step();                                   // pop edge with push
      drive(1'b0, 1'b0, 8'h00);
      check("pp_count_after", u16.fifo_count, 3);
      check("pp_ready_after", bus16.ready, 1'b1);
      step();
      check("pp_next_start", tx16, 1'b0);
      wait_idle(1'b0, 1000, "pp");

      // Reset during DATA bit 3 of 8'h3C with two more bytes queued.
      stim[0] = 8'h3C;
      stim[1] = 8'h11;
      stim[2] = 8'h22;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, stim[i]);
         step();
      end
      drive(1'b0, 1'b0, 8'h00);
      check("mr_start", tx16, 1'b0);           // just after edge N+2
      repeat (72) step();                       // middle of data bit 3
      check("mr_bit3", tx16, 1'b1);
      #2 arst = 1'b1;
      #1;
      check("mr_tx", tx16, 1'b1);
      check("mr_ready", bus16.ready, 1'b0);
      check("mr_busy", busy16, 1'b0);
      repeat (3) step();
      check("mr_ready_held", bus16.ready, 1'b0);
      #2 arst = 1'b0;
      step();
      check("mr_ready_rel", bus16.ready, 1'b1);
      low_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         step();
         if (tx16 !== 1'b1 || busy16 !== 1'b0) low_cnt++;
      end
      check("mr_no_frames", low_cnt, 0);
      check("mr_fifo_empty", u16.fifo_count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
